// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative RV32M multiply/divide unit for the execute stage. One M-type
// operation is accepted at a time and run either as a shift-add multiply or
// as a restoring divide over WIDTH iterations. A sign-correction cycle follows,
// and then a single-cycle valid result. While the unit is busy it holds a stall
// request to the hazard unit. A pipeline flush aborts the operation in flight.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      M-type instruction present in execute
//   funct3  in   3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                       100 DIV, 101 DIVU, 110 REM, 111 REMU
//   src_a   in   WIDTH  rs1 (multiplicand / dividend)
//   src_b   in   WIDTH  rs2 (multiplier / divisor)
//   flush   in   1      kill the in-flight operation
//   stall   out  1      freeze fetch/decode/execute
//   valid   out  1      result valid, one cycle
//   result  out  WIDTH  operation result
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's-complement negation, applied only when en is set.
  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                  input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic en);
    return en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         funct3_q, funct3_d;
  logic               sign_q, sign_d;
  // Shared working register: for multiply {partial product, multiplier},
  // for divide {remainder, quotient/dividend}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand magnitude or divisor magnitude, held for the whole operation.
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // ---------------------------------------------------------------------------
  // Accept-time decode of the incoming operation
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             is_div_in;
  logic             is_rem_in;
  logic             signed_a_in;
  logic             signed_b_in;
  logic             sign_a;
  logic             sign_b;
  logic             sign_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             div_by_zero;
  logic             div_ovf;
  logic             fast_in;
  logic [WIDTH-1:0] fast_res;

  assign accept      = (state_q == S_IDLE) && start && !flush;
  assign is_div_in   = funct3[2];
  assign is_rem_in   = funct3[2] & funct3[1];
  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM only.
  assign signed_a_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
  assign signed_b_in = (funct3 == 3'b001) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sign_a      = signed_a_in & src_a[WIDTH-1];
  assign sign_b      = signed_b_in & src_b[WIDTH-1];
  assign mag_a       = cond_neg_w(src_a, sign_a);
  assign mag_b       = cond_neg_w(src_b, sign_b);
  // Remainder takes the dividend's sign; product and quotient take the XOR.
  assign sign_in     = is_rem_in ? sign_a : (sign_a ^ sign_b);

  // Corner cases resolved without iterating: divide by zero, and the single
  // signed overflow case MIN / -1.
  assign div_by_zero = is_div_in && (src_b == '0);
  assign div_ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                       (src_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (src_b == {WIDTH{1'b1}});
  assign fast_in     = div_by_zero || div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_by_zero) begin
      fast_res = is_rem_in ? src_a : {WIDTH{1'b1}};
    end else if (div_ovf) begin
      fast_res = is_rem_in ? '0 : src_a;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration of the multiply and divide datapaths
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_step;

  // Add the multiplicand into the upper half when the multiplier LSB is set,
  // then shift right one, bringing the carry into the MSB.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // The shifted partial remainder needs one extra bit, because the divisor
  // can use the full width. When the trial subtraction succeeds, the
  // difference is smaller than the divisor. The low WIDTH bits of the
  // subtraction are therefore exact.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opd_q});
  assign div_diff  = div_shift[WIDTH-1:0] - opd_q;
  assign div_step  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // ---------------------------------------------------------------------------
  // Sign correction and result selection
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_res;

  assign prod_fix = cond_neg_2w(acc_q, sign_q);
  assign quo_fix  = cond_neg_w(acc_q[WIDTH-1:0], sign_q);
  assign rem_fix  = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], sign_q);

  always_comb begin
    fix_res = '0;
    case (funct3_q)
      3'b000:                 fix_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      opd_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      result_q <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = fast_in ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = flush ? S_IDLE : S_DONE;
      end
      default: begin
        // DONE always returns to IDLE. A start seen here is not accepted.
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d = funct3;
          sign_d   = sign_in;
          cnt_d    = CNT_W'(WIDTH);
          if (is_div_in) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            opd_d = mag_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag_b};
            opd_d = mag_a;
          end
          if (fast_in) begin
            result_d = fast_res;
          end
        end
      end
      S_CALC: begin
        if (!flush) begin
          cnt_d = cnt_q - CNT_W'(1);
          acc_d = funct3_q[2] ? div_step : mul_step;
        end
      end
      S_FIX: begin
        // A flush here leaves result holding its previous value.
        if (!flush) begin
          result_d = fix_res;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall  = (accept) || (state_q == S_CALC) || (state_q == S_FIX);
    valid  = (state_q == S_DONE) && !flush;
    result = result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed testbench for muldiv_sequencer (WIDTH=32). Inputs are driven on the
// falling edge. Outputs are sampled on the falling edge or between edges, and
// are compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         stall;
  logic         valid;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .stall  (stall),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation in the current cycle (cycle 0). The accept edge ends
  // that cycle. Then wait, within a bounded number of cycles, for valid.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int exp_lat);
    int cyc;
    int stall_low;
    bit seen;
    start  = 1'b1;
    funct3 = f3;
    src_a  = a;
    src_b  = b;
    flush  = 1'b0;
    #1 check({tag, " stall_c0"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the operands after accept. The operation must not notice.
    start  = 1'b0;
    funct3 = ~f3;
    src_a  = ~a;
    src_b  = ~b;
    cyc       = 0;
    stall_low = 0;
    seen      = 1'b0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (valid) begin
        seen = 1'b1;
        break;
      end
      if (!stall) stall_low++;
    end
    check({tag, " latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " stall_done"}, 32'(stall), 32'd0);
    if (exp_lat > 1) check({tag, " stall_busy"}, 32'(stall_low), 32'd0);
    @(negedge clk);
    check({tag, " valid_1cyc"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int valid_cnt;
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    src_a  = '0;
    src_b  = '0;
    repeat (2) @(negedge clk);
    check("reset stall", 32'(stall), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset result", result, 32'h0);
    rst = 1'b0;

    run_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("MULHU min*min",   3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("MULHSU -1*max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("DIVU 5/0",        3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("REM 5/0",         3'b110, 32'd5,         32'd0,         32'd5,         1);
    run_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("DIVU 100/7",      3'b101, 32'd100,       32'd7,         32'd14,        34);
    run_op("REMU 100/7",      3'b111, 32'd100,       32'd7,         32'd2,         34);

    // flush together with start in IDLE: not accepted, no stall
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = 3'b000;
    src_a  = 32'd9;
    src_b  = 32'd9;
    #1 check("idle flush stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1 check("idle flush no accept", 32'(stall), 32'd0);
    check("idle flush no valid", 32'(valid), 32'd0);

    // flush mid-CALC: back to IDLE with no valid, result unchanged (still 2)
    start  = 1'b1;
    funct3 = 3'b100;
    src_a  = 32'd100;
    src_b  = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    valid_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (valid) valid_cnt++;
    end
    flush = 1'b1;
    #1 check("flush calc stall", 32'(stall), 32'd1);
    check("flush calc valid", 32'(valid), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush no early valid", 32'(valid_cnt), 32'd0);
    check("flush stall drop", 32'(stall), 32'd0);
    check("flush valid", 32'(valid), 32'd0);
    check("flush result held", result, 32'd2);
    run_op("MUL 3*4 post-flush", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    // asynchronous reset mid-CALC
    start  = 1'b1;
    funct3 = 3'b001;
    src_a  = 32'd5;
    src_b  = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1 check("async rst stall", 32'(stall), 32'd0);
    check("async rst valid", 32'(valid), 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post-rst idle", 32'(stall), 32'd0);
    run_op("MULHU -1*2", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
